// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers (33-cycle latency).
// Define MULDIV_DIV_EN to include the restoring divider; otherwise DIV/DIVU requests are ignored.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*DATA_W-1:0] acc_q, step, prod;
  logic [DATA_W-1:0]   m_q, a_mag, b_mag, res_hi, res_lo;
  logic [DATA_W:0]     msum;
  logic                neg_res_q, op_ok, accept;
`ifdef MULDIV_DIV_EN
  logic                is_div_q, neg_rem_q, div0_q;
  logic [DATA_W:0]     diff;
`endif

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v, input logic sgn);
    mag = (sgn && v < 0) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] cneg32(input logic [DATA_W-1:0] v, input logic n);
    cneg32 = n ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cneg64(input logic [2*DATA_W-1:0] v, input logic n);
    cneg64 = n ? -v : v;
  endfunction

`ifdef MULDIV_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif
  assign accept = (state_q == IDLE) && start && op_ok;
  assign a_mag  = mag($signed(src_a), ~op[0]);
  assign b_mag  = mag($signed(src_b), ~op[0]);

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    msum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? m_q : '0)};
    step = {msum, acc_q[DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
    diff = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, m_q};
    if (is_div_q) begin
      if (!diff[DATA_W]) step = {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      else               step = {acc_q[2*DATA_W-2:0], 1'b0};
    end
`endif
  end

  // Sign correction applied in FIX
  always_comb begin
    prod   = cneg64(acc_q, neg_res_q);
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      res_hi = cneg32(acc_q[2*DATA_W-1:DATA_W], neg_rem_q);
      res_lo = div0_q ? '1 : cneg32(acc_q[DATA_W-1:0], neg_res_q);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (!start) begin
          if (hi_we) hi_d = src_a;
          if (lo_we) lo_d = src_a;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/working datapath carries no reset; the FSM decides when it is meaningful
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q     <= {{DATA_W{1'b0}}, (op[1] ? a_mag : b_mag)};
      m_q       <= op[1] ? b_mag : a_mag;
      neg_res_q <= ~op[0] & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
`ifdef MULDIV_DIV_EN
      is_div_q  <= op[1];
      neg_rem_q <= ~op[0] & src_a[DATA_W-1];
      div0_q    <= (src_b == '0);
`endif
    end else if (state_q == RUN) begin
      acc_q <= step;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model checked every cycle plus literal vectors.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full-width arithmetic from the operation definitions
  function automatic void calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l);
    longint          ps;
    logic [63:0]     pu;
    int              sa, sb;
    sa = a;
    sb = b;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin ps = longint'(sa) * longint'(sb); h = ps[63:32]; l = ps[31:0]; end
      2'b01: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
      2'b10: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = 32'h80000000; end
        else begin l = sa / sb; h = sa % sb; end
      end
      default: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;
  int          m_rem;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_done = 0; m_rem = 0; model_ok = 1'b1;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
      end else if (start && (!op[1] || DIV_EN)) begin
        calc(op, src_a, src_b, p_hi, p_lo);
        m_rem = 33;
      end else if (!start) begin
        if (hi_we) m_hi = src_a;
        if (lo_we) m_lo = src_a;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
      chk("model done", {31'd0, done}, {31'd0, m_done});
      chk("model hi", hi, m_hi);
      chk("model lo", lo, m_lo);
    end
  end

  // Called at a negedge; returns at the negedge after the start edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_check(input string nm, input logic [31:0] eh, input logic [31:0] el);
    int n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk({nm, " latency"}, n, 33);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    issue(o, a, b);
    wait_check(nm, eh, el);
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] v);
    @(negedge clk);
    hi_we = hw; lo_we = lw; src_a = v;
    @(posedge clk);
    @(negedge clk);
    hi_we = 0; lo_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    reset = 1; start = 0; hi_we = 0; lo_we = 0; op = 0; src_a = 0; src_b = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);

    mt(0, 1, 32'hA5A5A5A5);
    chk("mtlo lo", lo, 32'hA5A5A5A5);
    chk("mtlo hi", hi, 0);
    chk("mtlo done", {31'd0, done}, 0);
    mt(1, 0, 32'h12345678);
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi lo", lo, 32'hA5A5A5A5);
    mt(1, 1, 32'hCAFEF00D);
    chk("mtboth hi", hi, 32'hCAFEF00D);
    chk("mtboth lo", lo, 32'hCAFEF00D);

    // start wins over simultaneous register writes
    @(negedge clk);
    hi_we = 1; lo_we = 1;
    issue(2'b01, 32'd3, 32'd4);
    hi_we = 0; lo_we = 0;
    chk("startwin hi", hi, 32'hCAFEF00D);
    chk("startwin lo", lo, 32'hCAFEF00D);
    chk("startwin busy", {31'd0, busy}, 1);
    wait_check("startwin", 32'h0, 32'h0000000C);

    run_op("multu max2", 2'b01, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE);
    run_op("mult -3x7", 2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult minxmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run_op("multu maxsq", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult -1x-1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);

`ifdef MULDIV_DIV_EN
    run_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu 5/0", 2'b11, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF);
    run_op("div ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div 7/-2", 2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
    run_op("divu max/10", 2'b11, 32'hFFFFFFFF, 32'd10, 32'h5, 32'h19999999);
    run_op("div -5/0", 2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
`else
    @(negedge clk);
    issue(2'b10, 32'd10, 32'd3);
    chk("nodiv busy", {31'd0, busy}, 0);
    nd = 0;
    repeat (36) begin @(negedge clk); if (done) nd++; end
    chk("nodiv done count", nd, 0);
    chk("nodiv hi", hi, 32'h0);
    chk("nodiv lo", lo, 32'h1);
`endif

    // back-to-back: new start accepted in the done cycle
    run_op("multu 5x6", 2'b01, 32'd5, 32'd6, 32'h0, 32'd30);
    issue(2'b01, 32'd2, 32'd2);
    wait_check("b2b 2x2", 32'h0, 32'd4);

    // in-flight op ignores start/hi_we, then reset aborts it
    @(negedge clk);
    issue(2'b01, 32'd3, 32'd4);
    repeat (8) @(negedge clk);
    start = 1; op = 2'b01; src_a = 32'h0000FFFF; src_b = 32'd5; hi_we = 1;
    @(negedge clk);
    start = 0; hi_we = 0;
    chk("busyign busy", {31'd0, busy}, 1);
    chk("busyign hi", hi, 32'h0);
    chk("busyign lo", lo, 32'd4);
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    chk("abort busy", {31'd0, busy}, 0);
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("abort done count", nd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
